// File: rtl/linebuf_writer_if.sv
// Handshake bundle between the shared command register, the line-buffer write
// port and the command decoder that sits between them.
interface linebuf_writer_if #(
  parameter int LB_ADDR_BITS = 8
);
  logic                    has_data;
  logic [7:0]              rd_data;
  logic                    rd;
  logic                    lb_we;
  logic [LB_ADDR_BITS-1:0] lb_waddr;
  logic [15:0]             lb_wdata;
  logic                    busy;
  logic [7:0]              err_count;

  modport master (
    input  has_data, rd_data,
    output rd, lb_we, lb_waddr, lb_wdata, busy, err_count
  );

  modport slave (
    output has_data, rd_data,
    input  rd, lb_we, lb_waddr, lb_wdata, busy, err_count
  );
endinterface

// File: rtl/linebuf_writer.sv
// Byte-protocol decoder feeding the scan-line buffer write port:
// set address, burst word write and whole-buffer fill.
//
// state  | meaning
// S_IDLE | waiting for an opcode byte
// S_ADDR | waiting for the address byte of SET_ADDR
// S_HI   | waiting for the high byte of a data word
// S_LO   | waiting for the low byte; writes the word (WRITE) or starts a fill
// S_FILL | one write per cycle across the whole buffer, no bytes accepted
module linebuf_writer #(
  parameter int LB_ADDR_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  linebuf_writer_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_HI, S_LO, S_FILL} state_t;

  state_t                  state;
  logic [LB_ADDR_BITS-1:0] addr;
  logic [3:0]              words_left;
  logic [7:0]              hi_byte;
  logic                    cmd_fill;
  logic                    accept;

  // rd doubles as the "byte just consumed" flag, which caps the rate at one byte per two cycles
  assign accept = bus.has_data && !bus.rd && (state != S_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      words_left    <= '0;
      hi_byte       <= '0;
      cmd_fill      <= 1'b0;
      bus.rd        <= 1'b0;
      bus.lb_we     <= 1'b0;
      bus.lb_waddr  <= '0;
      bus.lb_wdata  <= '0;
      bus.busy      <= 1'b0;
      bus.err_count <= '0;
    end else begin
      bus.rd    <= accept;
      bus.lb_we <= 1'b0;
      bus.busy  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (bus.rd_data[7:4])
              4'h0: ;
              4'h1: state <= S_ADDR;
              4'h2: begin
                cmd_fill   <= 1'b0;
                words_left <= bus.rd_data[3:0];
                state      <= S_HI;
              end
              4'h3: begin
                cmd_fill <= 1'b1;
                state    <= S_HI;
              end
              default: begin
                if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (accept) begin
            addr  <= LB_ADDR_BITS'(bus.rd_data);
            state <= S_IDLE;
          end
        end
        S_HI: begin
          if (accept) begin
            hi_byte <= bus.rd_data;
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            bus.lb_we    <= 1'b1;
            bus.lb_wdata <= {hi_byte, bus.rd_data};
            if (cmd_fill) begin
              // the first fill word goes out on this edge, so the fill state resumes at 1
              bus.lb_waddr <= '0;
              addr         <= LB_ADDR_BITS'(1);
              bus.busy     <= 1'b1;
              state        <= S_FILL;
            end else begin
              bus.lb_waddr <= addr;
              addr         <= addr + 1'b1;
              if (words_left == 4'd0) begin
                state <= S_IDLE;
              end else begin
                words_left <= words_left - 4'd1;
                state      <= S_HI;
              end
            end
          end
        end
        S_FILL: begin
          bus.lb_we    <= 1'b1;
          bus.busy     <= 1'b1;
          bus.lb_waddr <= addr;
          addr         <= addr + 1'b1;
          // leaving on the last write lets the next byte land on the edge where busy drops
          if (addr == '1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linebuf_writer.sv
// Bench for linebuf_writer: streams command bytes and scores every line-buffer
// write against a queue of expected (address, data) pairs.
module tb_linebuf_writer;

  localparam int AW = 8;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  linebuf_writer_if #(.LB_ADDR_BITS(AW)) bus ();

  linebuf_writer #(.LB_ADDR_BITS(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_cnt   = 0;
  logic prev_rd  = 1'b0;
  logic mon_en   = 1'b1;
  wr_t  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  // leaves has_data high so consecutive calls exercise the full-rate handshake
  task automatic send_byte(input logic [7:0] b);
    bit seen = 1'b0;
    bus.rd_data  = b;
    bus.has_data = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.rd) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rd_timeout", {31'd0, bus.rd}, 32'd1);
  endtask

  task automatic release_bus();
    bus.has_data = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
    end else begin
      if (bus.rd) begin
        rd_cnt++;
        chk("rd_consec", {31'd0, prev_rd}, 32'd0);
      end
      prev_rd = bus.rd;
      if (bus.lb_we && mon_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", {24'd0, bus.lb_waddr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("waddr", {24'd0, bus.lb_waddr}, {24'd0, e.a});
          chk("wdata", {16'd0, bus.lb_wdata}, {16'd0, e.d});
        end
      end
    end
  end

  initial begin
    int rd_base;
    int busy_cnt;

    bus.has_data = 1'b0;
    bus.rd_data  = 8'h00;
    idle(3);
    chk("rst_rd",    {31'd0, bus.rd},    32'd0);
    chk("rst_we",    {31'd0, bus.lb_we}, 32'd0);
    chk("rst_waddr", {24'd0, bus.lb_waddr}, 32'd0);
    chk("rst_wdata", {16'd0, bus.lb_wdata}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_err",   {24'd0, bus.err_count}, 32'd0);
    rst = 1'b0;
    idle(2);

    // SET_ADDR then a two-word burst
    push_wr(8'd5, 16'hABCD);
    push_wr(8'd6, 16'h1234);
    rd_base = rd_cnt;
    send_byte(8'h10); send_byte(8'h05); send_byte(8'h21);
    send_byte(8'hAB); send_byte(8'hCD);
    chk("we_latency", {31'd0, bus.lb_we}, 32'd1);
    send_byte(8'h12); send_byte(8'h34);
    release_bus();
    idle(4);
    chk("rd_pulses_7", rd_cnt - rd_base, 32'd7);
    chk("sb_drain_1", exp_q.size(), 32'd0);

    // burst crossing the top address
    push_wr(8'd255, 16'h1111);
    push_wr(8'd0,   16'h2222);
    send_byte(8'h10); send_byte(8'hFF); send_byte(8'h21);
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
    release_bus();
    idle(4);
    chk("sb_drain_2", exp_q.size(), 32'd0);

    // whole-buffer fill with has_data held high throughout
    for (int i = 0; i < 256; i++) push_wr(AW'(i), 16'h5AA5);
    push_wr(8'd0, 16'h0001);
    send_byte(8'h30); send_byte(8'h5A); send_byte(8'hA5);
    bus.rd_data = 8'h20;
    busy_cnt = 0;
    for (int i = 0; i < 400 && bus.busy; i++) begin
      busy_cnt++;
      if (busy_cnt > 1) chk("rd_in_fill", {31'd0, bus.rd}, 32'd0);
      @(negedge clk);
    end
    chk("fill_cycles", busy_cnt, 32'd256);
    chk("fill_we_off", {31'd0, bus.lb_we}, 32'd0);
    chk("accept_at_busy_fall", {31'd0, bus.rd}, 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    release_bus();
    idle(4);
    chk("sb_drain_fill", exp_q.size(), 32'd0);

    // unknown opcodes saturate the error counter
    send_byte(8'h7F);
    idle(1);
    chk("err_first", {24'd0, bus.err_count}, 32'd1);
    for (int i = 1; i < 300; i++) send_byte(8'h7F);
    release_bus();
    idle(2);
    chk("err_sat", {24'd0, bus.err_count}, 32'd255);
    send_byte(8'h05);
    release_bus();
    idle(2);
    chk("err_nop", {24'd0, bus.err_count}, 32'd255);

    // reset in the middle of a fill
    mon_en = 1'b0;
    send_byte(8'h30); send_byte(8'h77); send_byte(8'h88);
    release_bus();
    idle(100);
    chk("midfill_we",    {31'd0, bus.lb_we}, 32'd1);
    chk("midfill_waddr", {24'd0, bus.lb_waddr}, 32'd100);
    rst = 1'b1;
    idle(1);
    chk("abort_we",   {31'd0, bus.lb_we}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy},  32'd0);
    chk("abort_err",  {24'd0, bus.err_count}, 32'd0);
    rst = 1'b0;
    idle(2);
    chk("abort_quiet", {31'd0, bus.lb_we}, 32'd0);
    mon_en = 1'b1;
    push_wr(8'd0, 16'h1234);
    send_byte(8'h20); send_byte(8'h12); send_byte(8'h34);
    release_bus();
    idle(4);
    chk("sb_drain_abort", exp_q.size(), 32'd0);

    // has_data stuck high: strictly alternating rd
    rd_base = rd_cnt;
    bus.rd_data  = 8'h00;
    bus.has_data = 1'b1;
    idle(40);
    release_bus();
    idle(3);
    chk("b2b_rd_pulses", rd_cnt - rd_base, 32'd20);

    idle(5);
    chk("sb_final", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
